// File: rtl/delay_tap_monitor_if.sv
// delay_tap_monitor_if: stimulus and result bundle between the delay line under test and its monitor
interface delay_tap_monitor_if #(
    parameter int NTAPS = 5,
    parameter int CW    = 8
);
    logic                  arm;
    logic                  trig;
    logic [NTAPS-1:0]      taps;
    logic                  busy;
    logic                  done;
    logic [NTAPS-1:0]      seen;
    logic                  timeout;
    logic                  order_err;
    logic [NTAPS*CW-1:0]   delays;
    modport master (output arm, trig, taps, input busy, done, seen, timeout, order_err, delays);
    modport slave  (input arm, trig, taps, output busy, done, seen, timeout, order_err, delays);
endinterface

// File: rtl/delay_tap_monitor.sv
// delay_tap_monitor: measures trigger-to-tap delays of a tapped delay line, flags misordering and timeout
module delay_tap_monitor #(
    parameter int NTAPS = 5,
    parameter int CW    = 8,
    parameter int TMAX  = 255
) (
    input logic             clk,
    input logic             reset,
    delay_tap_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;
    state_t              state_q, state_d;
    logic                trig_q;
    logic [NTAPS-1:0]    taps_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NTAPS-1:0]    seen_q, seen_d;
    logic [NTAPS*CW-1:0] delays_q, delays_d;
    logic                timeout_q, timeout_d;
    logic                order_q, order_d;
    logic                done_q, done_d;
    logic                trig_rise;
    logic [NTAPS-1:0]    tap_rise;
    logic [NTAPS-1:0]    cap;
    assign trig_rise     = bus.trig & ~trig_q;
    assign tap_rise      = bus.taps & ~taps_q;
    assign bus.busy      = (state_q == ARMED) || (state_q == MEASURE);
    assign bus.done      = done_q;
    assign bus.seen      = seen_q;
    assign bus.timeout   = timeout_q;
    assign bus.order_err = order_q;
    assign bus.delays    = delays_q;
    // Next state: arm handling, trigger wait, per-tap capture, completion and ordering check
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        seen_d    = seen_q;
        delays_d  = delays_q;
        timeout_d = timeout_q;
        order_d   = order_q;
        done_d    = 1'b0;
        cap       = '0;
        case (state_q)
            IDLE, DONE: if (bus.arm) begin
                state_d   = ARMED;
                cnt_d     = '0;
                seen_d    = '0;
                delays_d  = '0;
                timeout_d = 1'b0;
                order_d   = 1'b0;
            end
            ARMED: if (trig_rise) begin
                cap     = tap_rise;
                cnt_d   = CW'(1);
                done_d  = &tap_rise;
                state_d = (&tap_rise) ? DONE : MEASURE;
            end
            MEASURE: begin
                cap = tap_rise & ~seen_q;
                if (&(seen_q | cap)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (cnt_q == CW'(TMAX)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end else
                    cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
        seen_d = seen_d | cap;
        for (int i = 0; i < NTAPS; i++)
            if (cap[i]) delays_d[i*CW +: CW] = cnt_q;
        for (int i = 1; i < NTAPS; i++)
            if (cap[i] && !(seen_q[i-1] || cap[i-1])) order_d = 1'b1;
    end
    // State and result registers with synchronous reset; edge-detect samples track inputs every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            trig_q    <= 1'b0;
            taps_q    <= '0;
            cnt_q     <= '0;
            seen_q    <= '0;
            delays_q  <= '0;
            timeout_q <= 1'b0;
            order_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            trig_q    <= bus.trig;
            taps_q    <= bus.taps;
            cnt_q     <= cnt_d;
            seen_q    <= seen_d;
            delays_q  <= delays_d;
            timeout_q <= timeout_d;
            order_q   <= order_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_delay_tap_monitor.sv
// tb_delay_tap_monitor: directed vectors for the delay tap monitor, nominal and short-timeout instances
module tb_delay_tap_monitor;
    localparam int NT = 5;
    localparam int CW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic arm = 1'b0;
    logic trig = 1'b0;
    logic [NT-1:0] taps = '0;
    int n_vec = 0;
    int n_bad = 0;
    delay_tap_monitor_if #(.NTAPS(NT), .CW(CW)) ifa ();
    delay_tap_monitor_if #(.NTAPS(NT), .CW(CW)) ifb ();
    assign ifa.arm = arm;
    assign ifa.trig = trig;
    assign ifa.taps = taps;
    assign ifb.arm = arm;
    assign ifb.trig = trig;
    assign ifb.taps = taps;
    delay_tap_monitor #(.NTAPS(NT), .CW(CW), .TMAX(255)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    delay_tap_monitor #(.NTAPS(NT), .CW(CW), .TMAX(20)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic arm_it();
        trig = 1'b0;
        taps = '0;
        step(2);
        arm = 1'b1;
        step(1);
        arm = 1'b0;
        check("busy_after_arm", 64'(ifa.busy), 64'd1);
    endtask
    task automatic run(input int dl[NT], input int last, input bit quirk);
        for (int i = 0; i < NT; i++) taps[i] = (dl[i] == 0);
        trig = 1'b1;
        step(1);
        for (int d = 1; d <= last; d++) begin
            for (int i = 0; i < NT; i++) taps[i] = (dl[i] >= 0) && (d >= dl[i]);
            if (quirk) begin
                if (d == 1) trig = 1'b0;
                if (d == 2) trig = 1'b1;
                arm = (d == 3);
                if (d == 4) taps[0] = 1'b0;
            end
            step(1);
        end
        arm = 1'b0;
    endtask
    initial begin
        step(2);
        check("rst_busy", 64'(ifa.busy), 64'd0);
        check("rst_done", 64'(ifa.done), 64'd0);
        check("rst_seen", 64'(ifa.seen), 64'd0);
        check("rst_timeout", 64'(ifa.timeout), 64'd0);
        check("rst_order", 64'(ifa.order_err), 64'd0);
        check("rst_delays", 64'(ifa.delays), 64'd0);
        reset = 1'b0;
        arm_it();
        run('{5, 10, 15, 20, 25}, 25, 1'b0);
        check("nom_done", 64'(ifa.done), 64'd1);
        check("nom_busy", 64'(ifa.busy), 64'd0);
        check("nom_seen", 64'(ifa.seen), 64'h1f);
        check("nom_delays", 64'(ifa.delays), 64'h19_14_0f_0a_05);
        check("nom_timeout", 64'(ifa.timeout), 64'd0);
        check("nom_order", 64'(ifa.order_err), 64'd0);
        step(1);
        check("nom_done_pulse", 64'(ifa.done), 64'd0);
        check("nom_hold", 64'(ifa.delays), 64'h19_14_0f_0a_05);
        arm_it();
        run('{0, 3, 3, 3, 3}, 3, 1'b0);
        check("sim_done", 64'(ifa.done), 64'd1);
        check("sim_delays", 64'(ifa.delays), 64'h03_03_03_03_00);
        check("sim_order", 64'(ifa.order_err), 64'd0);
        arm_it();
        check("arm_clears", 64'(ifa.seen), 64'd0);
        run('{2, 6, 4, 5, 8}, 8, 1'b0);
        check("mis_done", 64'(ifa.done), 64'd1);
        check("mis_delays", 64'(ifa.delays), 64'h08_05_04_06_02);
        check("mis_order", 64'(ifa.order_err), 64'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        arm_it();
        run('{1, 2, 3, 4, -1}, 19, 1'b0);
        check("to_not_yet", 64'(ifb.done), 64'd0);
        step(1);
        check("to_done", 64'(ifb.done), 64'd1);
        check("to_busy", 64'(ifb.busy), 64'd0);
        check("to_seen", 64'(ifb.seen), 64'h0f);
        check("to_timeout", 64'(ifb.timeout), 64'd1);
        check("to_delays", 64'(ifb.delays), 64'h00_04_03_02_01);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        arm_it();
        taps[0] = 1'b1;
        step(1);
        taps[0] = 1'b0;
        step(1);
        check("pre_trig_seen", 64'(ifa.seen), 64'd0);
        run('{3, 4, 5, 6, 7}, 7, 1'b1);
        check("ign_done", 64'(ifa.done), 64'd1);
        check("ign_delays", 64'(ifa.delays), 64'h07_06_05_04_03);
        check("ign_order", 64'(ifa.order_err), 64'd0);
        arm_it();
        run('{2, 4, 6, 8, 10}, 7, 1'b0);
        check("mid_seen", 64'(ifa.seen), 64'h07);
        reset = 1'b1;
        trig = 1'b0;
        taps = '0;
        step(1);
        reset = 1'b0;
        check("mrst_busy", 64'(ifa.busy), 64'd0);
        check("mrst_seen", 64'(ifa.seen), 64'd0);
        check("mrst_delays", 64'(ifa.delays), 64'd0);
        check("mrst_done", 64'(ifa.done), 64'd0);
        arm_it();
        run('{1, 2, 3, 4, 5}, 5, 1'b0);
        check("fresh_done", 64'(ifa.done), 64'd1);
        check("fresh_delays", 64'(ifa.delays), 64'h05_04_03_02_01);
        check("fresh_timeout", 64'(ifa.timeout), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/delay_tap_monitor.md
# delay_tap_monitor

Clocked checker for the receiving end of a tapped delay line. It watches the delay line's input (trigger) and its NTAPS tap outputs, counts clock cycles from the trigger's rising edge to each tap's first rising edge, and reports per-tap delays plus ordering and timeout flags. It sits beside the synthesizable timing-chain replacement in the CADR clock path, where it lets simulation and bring-up confirm that tap spacing and ordering match the design intent.

## Interface
- NTAPS, 5, number of tap inputs
- CW, 8, width of each delay count
- TMAX, 255, last cycle count measured before timeout; must be ≤ 2^CW−1
- clk  input  1  sole clock; all inputs must already be synchronous to clk
- reset  input  1  synchronous, active-high; clears all state and outputs
- arm  input  1  start a new measurement; accepted only in IDLE or DONE
- trig  input  1  delay-line input under observation
- taps  input  NTAPS  tap outputs; bit i is the i-th tap, in increasing nominal delay
- busy  output  1  high in ARMED and MEASURE
- done  output  1  one-cycle pulse on entry to DONE
- seen  output  NTAPS  bit i set once tap i's delay has been captured
- timeout  output  1  DONE was reached with some tap not seen
- order_err  output  1  some tap rose strictly before a lower-numbered tap
- delays  output  NTAPS*CW  packed counts; tap i occupies bits [i*CW +: CW]

## Operation
- Edge detection: trig_q and taps_q hold the previous-cycle samples. A rising edge is cur & ~prev. After reset the prev registers are 0, so an input that is already high counts as rising on the first cycle.
- States: IDLE, ARMED, MEASURE, DONE. The reset state is IDLE.
- IDLE/DONE + arm: clear seen, delays, timeout and order_err; go to ARMED. In all other states arm is ignored.
- ARMED: wait for a trig rising edge. Tap edges before it are ignored. On the trig edge:
  - capture with count 0 any tap rising in the same cycle;
  - set cnt to 1 and go to MEASURE.
  - If every tap is captured in that cycle, go straight to DONE.
- MEASURE: each tap rising edge whose seen bit is clear loads delays[i] with cnt and sets seen[i]. cnt then increments.
  - Further edges on a tap that is already seen are ignored.
  - Further trig edges are ignored.
- Completion:
  - When all seen bits are set, including bits set this cycle, go to DONE with timeout = 0.
  - Otherwise, if cnt == TMAX after this cycle's captures, go to DONE with timeout = 1. Delays for unseen taps stay 0.
- order_err: set when tap i (i > 0) is captured in a cycle where tap i−1 is neither already seen nor captured in the same cycle. Equal delays are legal. The flag is sticky until the next arm.
- DONE: all results hold until the next arm or reset.

## Timing
- Reset values: busy = 0, done = 0, seen = 0, timeout = 0, order_err = 0, delays = 0, cnt = 0, trig_q = 0, taps_q = 0, state IDLE.
- Reset asserted in any state takes priority and forces the reset values on the next edge. A measurement in progress is discarded.
- The arm edge is captured at clock k; busy is high from k+1.
- A trig rising edge sampled at clock k followed by a tap rising edge sampled at clock k+d gives delay = d, for 0 ≤ d ≤ TMAX.
- done pulses at the clock after the last capture, or after the cnt == TMAX check. busy falls in the same cycle that done rises.
- cnt never wraps: the largest value captured is TMAX.

## Test plan
- Nominal chain: arm; trig rises at cycle 10; taps 0..4 rise at cycles 15, 20, 25, 30, 35 → delays 5, 10, 15, 20, 25; seen = 11111; done one cycle after cycle 35; timeout = 0; order_err = 0.
- Simultaneous edges: tap 0 rises with trig and taps 1..4 rise together 3 cycles later → delays 0, 3, 3, 3, 3; order_err = 0.
- Misordering: tap 2 rises at d = 4 and tap 1 at d = 6 → delays[1] = 6, delays[2] = 4, order_err = 1.
- Timeout with TMAX = 20: tap 4 never rises → done after cnt reaches 20; seen = 01111; timeout = 1; delays[4] = 0.
- Ignored events:
  - tap pulse before trig → no capture;
  - second trig edge during MEASURE → no change;
  - arm during MEASURE → no change;
  - second rising edge on tap 0 → first delay kept.
- Reset mid-measurement: reset asserted at d = 7 → all outputs 0 and state IDLE the next cycle. A fresh arm then measures correctly.
